// File: rtl/single_port_register_arbiter.sv
// Round-robin front end for a shared single-port word array: grants one requester
// per cycle, sanitises byte-enable codes, and returns tagged responses two cycles later.

module spra_lane (
  input  logic       write,
  input  logic [3:0] code,
  output logic       wr_ok,
  output logic       wr_bad
);
  logic legal;

  always_comb begin
    legal = 1'b0;
    case (code)
      4'hf, 4'h7, 4'h3, 4'h1: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  assign wr_ok  = write & legal;
  assign wr_bad = write & ~legal;
endmodule

module single_port_register_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 hold,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ-1:0][3:0]              req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]        req_wdata,
  output logic                                 rsp_valid,
  output logic [ID_WIDTH-1:0]                  rsp_id,
  output logic [WIDTH-1:0]                     rsp_rdata,
  output logic                                 rsp_err,
  output logic                                 busy,
  output logic                                 ram_en,
  output logic [3:0]                           ram_we,
  output logic [ADDR_WIDTH-1:0]                ram_addr,
  output logic [WIDTH-1:0]                     ram_din,
  input  logic [WIDTH-1:0]                     ram_dout
);
  localparam int STAGES = 2;

  logic [NUM_REQ-1:0]  wr_ok, wr_bad;
  logic [ID_WIDTH-1:0] rr_ptr, win;
  logic                found, grant;
  logic [STAGES:1]     vld_pipe;
  logic [ID_WIDTH-1:0] b_id;
  logic                b_err, b_rd, c_rd;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    spra_lane u_lane (
      .write  (req_write[i]),
      .code   (req_we[i]),
      .wr_ok  (wr_ok[i]),
      .wr_bad (wr_bad[i])
    );
  end

  // Rotating search from rr_ptr; the extra index bit absorbs the wrap before reduction.
  always_comb begin
    logic [ID_WIDTH:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
      if (idx >= (ID_WIDTH+1)'(NUM_REQ)) idx = idx - (ID_WIDTH+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign grant = found & ~hold;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      vld_pipe  <= '0;
      b_id      <= '0;
      b_err     <= 1'b0;
      b_rd      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      c_rd      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], grant};
      if (grant) begin
        rr_ptr   <= (win == ID_WIDTH'(NUM_REQ-1)) ? '0 : win + 1'b1;
        b_id     <= win;
        b_err    <= wr_bad[win];
        b_rd     <= ~req_write[win];
        // Illegal codes degrade to a read so the array word is never zeroed.
        ram_en   <= wr_ok[win];
        ram_we   <= wr_ok[win] ? req_we[win] : 4'h0;
        ram_addr <= req_addr[win];
        if (wr_ok[win]) ram_din <= req_wdata[win];
      end else begin
        ram_en <= 1'b0;
        ram_we <= 4'h0;
      end
      rsp_id  <= b_id;
      rsp_err <= vld_pipe[1] & b_err;
      c_rd    <= vld_pipe[1] & b_rd;
    end
  end

  // The array registers its output on the same edge that raises rsp_valid.
  assign rsp_valid = vld_pipe[2];
  assign rsp_rdata = c_rd ? ram_dout : '0;
  assign busy      = |vld_pipe;
endmodule

// File: tb/tb_single_port_register_arbiter.sv
// Directed vector bench for single_port_register_arbiter with a behavioural array model.

module tb_single_port_register_arbiter;
  localparam int NUM_REQ = 2;
  localparam int AW      = 10;
  localparam int IDW     = 1;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          hold = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0, req_ready, req_write = '0;
  logic [NUM_REQ-1:0][3:0]       req_we = '0;
  logic [NUM_REQ-1:0][AW-1:0]    req_addr = '0;
  logic [NUM_REQ-1:0][31:0]      req_wdata = '0;
  logic                          rsp_valid, rsp_err, busy, ram_en;
  logic [IDW-1:0]                rsp_id;
  logic [31:0]                   rsp_rdata, ram_din, ram_dout;
  logic [3:0]                    ram_we;
  logic [AW-1:0]                 ram_addr;

  int tests = 0, fails = 0, bad_wr = 0;

  single_port_register_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Array model: preloaded while reset is low, registered read output.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < 1024; j++) mem[j] <= 32'h0;
      mem[16] <= 32'hCAFE0010;
      mem[48] <= 32'h12345678;
    end else if (ram_en) begin
      case (ram_we)
        4'hf: mem[ram_addr]        <= ram_din;
        4'h7: mem[ram_addr][23:0]  <= ram_din[23:0];
        4'h3: mem[ram_addr][15:0]  <= ram_din[15:0];
        4'h1: mem[ram_addr][7:0]   <= ram_din[7:0];
        default: mem[ram_addr]     <= 32'h0;
      endcase
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  always @(negedge clk) if (rst_n && ram_en && ram_addr == 10'h030) bad_wr++;

  typedef struct {
    logic        hold;
    logic [1:0]  valid, write;
    logic [3:0]  we0, we1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  e_ready;
    logic        e_vld, e_id;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic h, input logic [1:0] v, input logic [1:0] w,
                     input logic [3:0] we0, input logic [9:0] a0, input logic [31:0] d0,
                     input logic [3:0] we1, input logic [9:0] a1, input logic [31:0] d1,
                     input logic [1:0] er, input logic ev, input logic eid,
                     input logic [31:0] ed, input logic ee);
    vec_t x;
    x.hold = h; x.valid = v; x.write = w;
    x.we0 = we0; x.a0 = a0; x.d0 = d0; x.we1 = we1; x.a1 = a1; x.d1 = d1;
    x.e_ready = er; x.e_vld = ev; x.e_id = eid; x.e_rdata = ed; x.e_err = ee;
    vecs.push_back(x);
  endtask

  task automatic idle(input logic ev, input logic eid, input logic [31:0] ed, input logic ee);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ev, eid, ed, ee);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    hold = x.hold; req_valid = x.valid; req_write = x.write;
    req_we[0] = x.we0; req_addr[0] = x.a0; req_wdata[0] = x.d0;
    req_we[1] = x.we1; req_addr[1] = x.a1; req_wdata[1] = x.d1;
  endtask

  initial begin
    #1;
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_id",    32'(rsp_id), 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err",   32'(rsp_err), 0);
    chk("rst busy",      32'(busy), 0);
    chk("rst ram_en",    32'(ram_en), 0);
    chk("rst ram_we",    32'(ram_we), 0);
    chk("rst ram_addr",  32'(ram_addr), 0);
    chk("rst ram_din",   ram_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle(0, 0, 0, 0);
    add(0, 2'b01, 2'b00, 0, 10'h010, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    add(0, 2'b01, 2'b01, 4'hf, 10'h020, 32'hDEADBEEF, 0, 0, 0, 2'b01, 1, 0, 32'hCAFE0010, 0);
    add(0, 2'b10, 2'b10, 0, 0, 0, 4'h1, 10'h020, 32'h00000011, 2'b10, 0, 0, 0, 0);
    add(0, 2'b01, 2'b00, 0, 10'h020, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
    idle(1, 1, 0, 0);
    idle(1, 0, 32'hDEADBE11, 0);
    for (int k = 0; k < 8; k++)
      add(0, 2'b11, 2'b00, 0, 10'h010, 0, 0, 10'h020, 0,
          (k % 2 == 0) ? 2'b10 : 2'b01, k >= 2, (k % 2 == 0),
          (k >= 2) ? ((k % 2 == 0) ? 32'hDEADBE11 : 32'hCAFE0010) : 32'h0, 0);
    idle(1, 1, 32'hDEADBE11, 0);
    idle(1, 0, 32'hCAFE0010, 0);
    add(0, 2'b01, 2'b01, 4'h5, 10'h030, 32'hFFFFFFFF, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 2'b10, 2'b00, 0, 0, 0, 0, 10'h030, 0, 2'b10, 0, 0, 0, 0);
    idle(1, 0, 0, 1);
    idle(1, 1, 32'h12345678, 0);
    for (int k = 0; k < 3; k++)
      add(1, 2'b11, 2'b00, 0, 10'h010, 0, 0, 10'h020, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 2'b00, 0, 10'h010, 0, 0, 10'h020, 0, 2'b01, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(1, 0, 32'hCAFE0010, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d rsp_id", i),  32'(rsp_id), 32'(vecs[i].e_id));
        chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
      end
    end
    chk("illegal code reached array", 32'(bad_wr), 0);

    // Reset while a read is in stage B; rr_ptr is 1 going in.
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 10'h010;
    #1 chk("pre-rst grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("pre-rst busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy", 32'(busy), 0);
    chk("mid-rst rsp_valid", 32'(rsp_valid), 0);
    chk("mid-rst ram_en", 32'(ram_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("post-rst rsp_valid %0d", k), 32'(rsp_valid), 0);
    end
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("post-rst rr_ptr grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 chk("post-rst rsp_valid", 32'(rsp_valid), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/single_port_register_arbiter.md
Name: single_port_register_arbiter

Overview:
- Shares one single-port register array (32-bit words, byte-lane partial writes) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready request handshake, one command issued per cycle.
- Sanitises byte-enable codes and returns tagged read/write responses at fixed latency.
- Sits between core-side masters (fetch, load/store, debug) and the register array instance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- WIDTH, 32, data width; fixed at 32 (4 byte lanes).
- DEPTH, 1024, words in the array.
- ADDR_WIDTH, $clog2(DEPTH), word address width.
- ID_WIDTH, $clog2(NUM_REQ), response tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  when high, no new request is granted.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_we  in  4*NUM_REQ  byte-enable code, slice i = [4i+3:4i].
- req_addr  in  ADDR_WIDTH*NUM_REQ  word address, packed per requester.
- req_wdata  in  WIDTH*NUM_REQ  write data, packed per requester.
- rsp_valid  out  1  response valid; no backpressure.
- rsp_id  out  ID_WIDTH  index of the requester this response belongs to.
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  the command carried an illegal write code.
- busy  out  1  a command is in flight (stage B or C occupied).
- ram_en  out  1  1 = write cycle, 0 = read cycle.
- ram_we  out  4  byte-enable code to the array.
- ram_addr  out  ADDR_WIDTH  array address.
- ram_din  out  WIDTH  array write data.
- ram_dout  in  WIDTH  array read data, registered inside the array.

Behaviour:
- Array contract:
  - ram_en=1 at edge: write per ram_we; legal codes are f (full word), 7 (low 3 bytes), 3 (low 2 bytes), 1 (low byte). Any other code zeroes the word.
  - ram_en=0 at edge: ram_dout <= ram[ram_addr].
  - The block therefore never drives ram_en=1 with an illegal code.
- Reset (async assert, sync-safe release):
  - All outputs 0: req_ready, rsp_*, busy, ram_en, ram_we, ram_addr, ram_din.
  - Round-robin pointer = 0 (requester 0 has highest priority first).
  - Any in-flight command is discarded; no response is produced for it.
- Arbitration (stage A, combinational):
  - Winner = first requester with req_valid set, searching from rr_ptr upward and wrapping.
  - req_ready[winner]=1 only if hold=0. req_ready may depend on req_valid.
  - Handshake completes when req_valid[i] & req_ready[i] at an edge. On that edge rr_ptr <= winner+1 modulo NUM_REQ.
  - rr_ptr is unchanged when there is no grant.
  - Requesters must keep their fields stable while valid and not granted.
- Stage B, command register, loaded on grant:
  - Legal write: ram_en=1, ram_we=code, ram_addr/ram_din from the request.
  - Read: ram_en=0, ram_we=0, ram_addr from the request.
  - Illegal write code: converted to a read of the same address (array untouched); err flag is carried.
  - No grant: ram_en=0, ram_we=0, ram_addr holds its last value (idle read, harmless).
- Stage C, response (the edge after stage B):
  - rsp_valid=1 with the captured id, write flag and err flag.
  - rsp_rdata = ram_dout for legal reads, else 0.
- Latency and throughput:
  - Grant edge T0, array operation edge T1, rsp_valid high during cycle T1..T2 (2 cycles, accept to response).
  - Full throughput: one grant per cycle, back-to-back.
  - Responses return in grant order.
- Read-after-write to the same address in consecutive grants returns the new data (the array write completes before the read edge).
- hold: takes effect combinationally; already-granted commands complete normally.
- busy = stage B valid | stage C valid.

Test Plan:
- Reset, then read addr 0x010 from requester 0 -> rsp_valid two cycles after grant, rsp_id=0, rsp_err=0; all outputs 0 before first grant.
- Req0 writes 0xDEADBEEF to 0x020 (we=f), then req1 writes 0x00000011 (we=1) to 0x020, then req0 reads 0x020 -> rdata 0xDEADBE11, responses in order with ids 0,1,0.
- Both requesters hold valid continuously for 8 cycles -> grants alternate 0,1,0,1,…; exactly 4 each; rsp_valid high every cycle after the pipeline fills.
- Write with we=4'h5 to 0x030 holding 0x12345678 -> rsp_err=1, rsp_rdata=0, ram_en never 1 for it; a subsequent read returns 0x12345678.
- hold=1 while both valid for 3 cycles -> req_ready=0, no rsp; release -> grant goes to the rr_ptr requester first.
- Assert rst_n=0 the cycle after a read grant -> no rsp_valid ever for it; busy=0 immediately; rr_ptr=0 after release.
